// File: rtl/dg_pattern_gen.sv
// Programmable-limit pattern counter (up-wrap, down-wrap, bounce, hold) with a
// period-toggle enable and an optionally inverted, valid-tagged delay pipeline.
module dg_pattern_gen #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DELAY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ctrl,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] limit,
  input  logic             invert,
  input  logic             clear,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             loop,
  output logic             enable
);

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_BNC  = 2'b10;
  localparam logic [1:0] MODE_HOLD = 2'b11;

  typedef enum logic {DIR_UP = 1'b0, DIR_DN = 1'b1} dir_t;

  logic [WIDTH-1:0] count_q, count_d;
  dir_t             dir_q, dir_d;
  logic             loop_q, loop_d;
  logic             enable_q, enable_d;
  logic             adv_q, adv_d;
  logic             adv_next;
  logic [WIDTH-1:0] limit_m1;
  logic [WIDTH-1:0] pipe_in;

  // Counter, direction and flag state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      dir_q    <= DIR_UP;
      loop_q   <= 1'b0;
      enable_q <= 1'b0;
      adv_q    <= 1'b0;
    end else begin
      count_q  <= count_d;
      dir_q    <= dir_d;
      loop_q   <= loop_d;
      enable_q <= enable_d;
      adv_q    <= adv_d;
    end
  end

  assign limit_m1 = (limit == '0) ? '0 : limit - WIDTH'(1);

  // Next-state: clear dominates advance; hold mode never advances
  always_comb begin
    count_d  = count_q;
    dir_d    = dir_q;
    loop_d   = 1'b0;
    enable_d = enable_q;
    adv_next = ctrl & ~clear & (mode != MODE_HOLD);
    adv_d    = adv_next;
    if (clear) begin
      count_d  = '0;
      dir_d    = DIR_UP;
      enable_d = 1'b0;
      adv_d    = 1'b0;
    end else if (adv_next) begin
      case (mode)
        MODE_UP: begin
          if (count_q >= limit) begin
            count_d = '0;
            loop_d  = 1'b1;
          end else begin
            count_d = count_q + WIDTH'(1);
          end
        end
        MODE_DOWN: begin
          if (count_q == '0) begin
            count_d = limit;
            loop_d  = 1'b1;
          end else if (count_q > limit) begin
            count_d = limit;
          end else begin
            count_d = count_q - WIDTH'(1);
          end
        end
        MODE_BNC: begin
          // A zero limit has no turnaround span, so every advance is a period
          if (limit == '0) begin
            count_d = '0;
            dir_d   = DIR_UP;
            loop_d  = 1'b1;
          end else if (dir_q == DIR_UP) begin
            if (count_q >= limit) begin
              dir_d   = DIR_DN;
              count_d = limit_m1;
            end else begin
              count_d = count_q + WIDTH'(1);
            end
          end else begin
            if (count_q == '0) begin
              dir_d   = DIR_UP;
              loop_d  = 1'b1;
              count_d = WIDTH'(1);
            end else begin
              count_d = count_q - WIDTH'(1);
            end
          end
        end
        default: ;
      endcase
      if (loop_d) enable_d = ~enable_q;
    end
  end

  assign loop    = loop_q;
  assign enable  = enable_q;
  assign pipe_in = invert ? ~count_q : count_q;

  generate
    if (DELAY == 0) begin : g_comb
      assign out       = pipe_in;
      assign out_valid = adv_q;
    end else begin : g_pipe
      logic [WIDTH-1:0] data_q [DELAY];
      logic [DELAY-1:0] valid_q;

      // Delay line keeps shifting regardless of advance or clear
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int unsigned i = 0; i < DELAY; i++) data_q[i] <= '0;
          valid_q <= '0;
        end else begin
          data_q[0]  <= pipe_in;
          valid_q[0] <= adv_q;
          for (int unsigned i = 1; i < DELAY; i++) begin
            data_q[i]  <= data_q[i-1];
            valid_q[i] <= valid_q[i-1];
          end
        end
      end

      assign out       = data_q[DELAY-1];
      assign out_valid = valid_q[DELAY-1];
    end
  endgenerate

endmodule

// File: tb/tb_dg_pattern_gen.sv
// Directed bench for dg_pattern_gen: a DELAY=2 and a DELAY=0 instance share stimulus;
// the DELAY=0 copy exposes the count register directly on its out port.
module tb_dg_pattern_gen;

  logic       clk;
  logic       rst_n;
  logic       ctrl;
  logic [1:0] mode;
  logic [3:0] limit;
  logic       invert;
  logic       clear;
  logic [3:0] out2, out0;
  logic       val2, val0, loop2, loop0, en2, en0;

  int checks   = 0;
  int failures = 0;

  logic [3:0] dn_cnt  [5]  = '{4'd3, 4'd2, 4'd1, 4'd0, 4'd3};
  logic [3:0] dn_loop [5]  = '{4'd1, 4'd0, 4'd0, 4'd0, 4'd1};
  logic [3:0] dn_en   [5]  = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd0};
  logic [3:0] bn_cnt  [13] = '{4'd1, 4'd2, 4'd3, 4'd2, 4'd1, 4'd0, 4'd1,
                               4'd2, 4'd3, 4'd2, 4'd1, 4'd0, 4'd1};
  logic       gp_ctrl [7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [1:0] gp_mode [7]  = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3};
  logic [3:0] gp_out0 [7]  = '{4'd2, 4'd2, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3};
  logic [3:0] gp_val0 [7]  = '{4'd1, 4'd0, 4'd0, 4'd1, 4'd0, 4'd0, 4'd0};
  logic [3:0] gp_val2 [7]  = '{4'd1, 4'd1, 4'd1, 4'd0, 4'd0, 4'd1, 4'd0};
  logic [3:0] gp_out2 [7]  = '{4'd0, 4'd1, 4'd2, 4'd2, 4'd2, 4'd3, 4'd3};
  logic [3:0] wr_cnt  [8]  = '{4'd4, 4'd5, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
  logic [3:0] wr_en   [8]  = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1};
  logic [3:0] rs_cnt  [4]  = '{4'd1, 4'd2, 4'd3, 4'd2};
  logic [3:0] z_en    [4]  = '{4'd1, 4'd0, 4'd1, 4'd0};

  dg_pattern_gen #(.WIDTH(4), .DELAY(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .ctrl(ctrl), .mode(mode), .limit(limit),
    .invert(invert), .clear(clear), .out(out2), .out_valid(val2),
    .loop(loop2), .enable(en2)
  );

  dg_pattern_gen #(.WIDTH(4), .DELAY(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .ctrl(ctrl), .mode(mode), .limit(limit),
    .invert(invert), .clear(clear), .out(out0), .out_valid(val0),
    .loop(loop0), .enable(en0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  initial begin
    rst_n = 1'b0; ctrl = 1'b0; mode = 2'd0; limit = 4'd5; invert = 1'b1; clear = 1'b0;
    step();
    step();
    chk("rst_out2",  out2,       4'd0);
    chk("rst_val2",  4'(val2),   4'd0);
    chk("rst_loop2", 4'(loop2),  4'd0);
    chk("rst_en2",   4'(en2),    4'd0);
    chk("rst_val0",  4'(val0),   4'd0);
    chk("rst_loop0", 4'(loop0),  4'd0);

    // Up-wrap, limit 5, inverted output
    rst_n = 1'b1; ctrl = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      chk("up_out0",  out0,      ~4'(k % 6));
      chk("up_loop0", 4'(loop0), 4'((k % 6) == 0));
      chk("up_loop2", 4'(loop2), 4'((k % 6) == 0));
      chk("up_en0",   4'(en0),   4'(k >= 6 && k < 12));
      chk("up_en2",   4'(en2),   4'(k >= 6 && k < 12));
      chk("up_val0",  4'(val0),  4'd1);
      if (k == 1) chk("up_out2_first", out2, 4'd0);
      if (k == 2) chk("up_val2_late", 4'(val2), 4'd0);
      if (k >= 3) begin
        chk("up_out2", out2,     ~4'((k - 2) % 6));
        chk("up_val2", 4'(val2), 4'd1);
      end
    end

    // Down-wrap, limit 3, then lower limit below count
    mode = 2'd1; limit = 4'd3; invert = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("dn_out0", out0,      dn_cnt[i]);
      chk("dn_loop", 4'(loop0), dn_loop[i]);
      chk("dn_en",   4'(en0),   dn_en[i]);
      if (i == 1) chk("dn_out2_inv_edge", out2, 4'd0);
      if (i == 2) chk("dn_out2", out2, 4'd3);
    end
    limit = 4'd1;
    step();
    chk("dn_clamp_out0", out0,      4'd1);
    chk("dn_clamp_loop", 4'(loop0), 4'd0);

    clear = 1'b1;
    step();
    chk("clr_out0", out0,      4'd0);
    chk("clr_loop", 4'(loop0), 4'd0);
    chk("clr_val0", 4'(val0),  4'd0);

    // Bounce, limit 3
    clear = 1'b0; mode = 2'd2; limit = 4'd3;
    for (int i = 0; i < 13; i++) begin
      step();
      chk("bn_out0", out0,      bn_cnt[i]);
      chk("bn_loop", 4'(loop0), 4'(i == 6 || i == 12));
      chk("bn_en",   4'(en0),   4'(i >= 6 && i < 12));
    end

    // Advance gaps and hold mode
    for (int i = 0; i < 7; i++) begin
      ctrl = gp_ctrl[i]; mode = gp_mode[i];
      step();
      chk("gap_out0", out0,      gp_out0[i]);
      chk("gap_val0", 4'(val0),  gp_val0[i]);
      chk("gap_loop", 4'(loop0), 4'd0);
      chk("gap_val2", 4'(val2),  gp_val2[i]);
      chk("gap_out2", out2,      gp_out2[i]);
    end

    // Up-wrap to limit, then clear colliding with the wrap
    mode = 2'd0; limit = 4'd5; ctrl = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("wr_out0", out0,      wr_cnt[i]);
      chk("wr_loop", 4'(loop0), 4'(i == 2));
      chk("wr_en",   4'(en0),   wr_en[i]);
    end
    clear = 1'b1;
    step();
    chk("cw_out0", out0,      4'd0);
    chk("cw_loop", 4'(loop0), 4'd0);
    chk("cw_en0",  4'(en0),   4'd0);
    chk("cw_en2",  4'(en2),   4'd0);
    chk("cw_val0", 4'(val0),  4'd0);
    clear = 1'b0;
    step();
    chk("cw_next", out0, 4'd1);
    step();
    chk("cw_val2", 4'(val2), 4'd0);
    chk("cw_out0b", out0, 4'd2);

    // Reset pulse mid-bounce while heading down
    mode = 2'd2; limit = 4'd3;
    step();
    chk("rb_top", out0, 4'd3);
    step();
    chk("rb_down", out0, 4'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_out0",  out0,      4'd0);
    chk("ar_val0",  4'(val0),  4'd0);
    chk("ar_out2",  out2,      4'd0);
    chk("ar_val2",  4'(val2),  4'd0);
    chk("ar_loop2", 4'(loop2), 4'd0);
    chk("ar_en2",   4'(en2),   4'd0);
    step();
    chk("ar_hold_out2", out2, 4'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rs_out0", out0,      rs_cnt[i]);
      chk("rs_loop", 4'(loop0), 4'd0);
      chk("rs_en",   4'(en0),   4'd0);
    end

    // Zero limit: loop on every advance, undelayed out
    mode = 2'd0; limit = 4'd0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("z_out0", out0,      4'd0);
      chk("z_loop", 4'(loop0), 4'd1);
      chk("z_en",   4'(en0),   z_en[i]);
    end
    invert = 1'b1;
    #1;
    chk("z_inv_comb", out0, 4'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dg_pattern_gen.md
Name: dg_pattern_gen

Overview:
Parametrised pattern generator for the digital test path. A programmable-limit counter runs in one of four modes: up-wrap, down-wrap, up/down bounce or hold. An enable flag toggles once per completed period. Each count value is optionally inverted and then delayed through a DELAY-stage pipeline, which carries a valid tag so downstream logic can tell advanced samples from held ones.

Parameters:
WIDTH, 8, counter/data width in bits (>=1)
DELAY, 2, number of register stages between counter and out (>=0; 0 = out driven combinationally from the count register)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
ctrl  in  1  advance request; counter steps on each rising edge where ctrl=1
mode  in  2  00 up-wrap, 01 down-wrap, 10 bounce, 11 hold
limit  in  WIDTH  terminal count, sampled every cycle
invert  in  1  1 = pipeline input is ~count, 0 = count
clear  in  1  synchronous clear of counter state
out  out  WIDTH  delayed (optionally inverted) count
out_valid  out  1  delayed advance tag aligned with out
loop  out  1  one-cycle pulse on period completion, undelayed
enable  out  1  toggles on every loop pulse

Behaviour:
- Reset (async, rst_n=0): count=0, dir=up, loop=0, enable=0, adv=0, all pipeline data/valid stages=0; out=0, out_valid=0. Deassertion mid-operation restarts from this state with no residue.
- Advance condition adv_n = ctrl & ~clear & (mode!=11). When adv_n=0, count and dir hold and loop=0 next cycle.
- Priority: clear > advance. With clear=1: count<=0, dir<=up, enable<=0, loop<=0, adv<=0. The pipeline keeps shifting, so out_valid drains to 0 after DELAY cycles.
- Mode 00, up-wrap: if count>=limit then count<=0 and loop<=1; else count<=count+1.
- Mode 01, down-wrap: if count==0 then count<=limit and loop<=1; else if count>limit then count<=limit (no loop); else count<=count-1.
- Mode 10, bounce, dir up: if count>=limit then dir<=down, count<=(limit==0 ? 0 : limit-1); else count+1.
- Mode 10, bounce, dir down: if count==0 then dir<=up, loop<=1, count<=(limit==0 ? 0 : 1); else count-1. Period = 2*limit cycles (limit>0).
- Mode 11, hold: count/dir frozen, loop=0. dir is retained across mode changes; it is only forced to up by clear or reset.
- limit==0: count stays 0 and loop pulses on every advance in modes 00/01/10.
- loop is registered and asserts in the same cycle the wrapped count becomes visible. On that same edge enable<=~enable.
- All arithmetic is modulo 2^WIDTH; comparisons are unsigned. Lowering limit below count causes a wrap at the next advance (up) or a clamp to limit (down).
- Pipeline input: stage0 data = invert ? ~count : count; stage0 valid = adv, where adv is the registered adv_n aligned with count. invert is applied at the input, so an invert change shows at out DELAY cycles later.
- Latency: out/out_valid reflect the count register DELAY cycles later. With DELAY=0 they are combinational from count/adv. With WIDTH=1 all modes still apply.

Test Plan:
- WIDTH=4, DELAY=2, mode=00, limit=5, invert=1, ctrl=1 from reset -> count 1,2,3,4,5,0,1…; loop high only when count=0 (every 6 cycles); enable toggles there; out = 15-count two cycles later (E,D,C,B,A,F); out_valid rises 2 cycles after the first advance.
- mode=01, limit=3, invert=0 -> count 0→3,2,1,0,3; loop on each 0→3 step; then set limit=1 while count=3 -> next advance count=1 with no loop.
- mode=10, limit=3 -> count 1,2,3,2,1,0,1,2…; loop only at 0→1 turnaround (period 6); enable toggles once per period.
- ctrl pattern 1,0,0,1 and mode=11 for 3 cycles -> count holds during gaps and hold, loop=0, out_valid=0 for the matching delayed cycles, out keeps last value.
- clear asserted in the same cycle as an up-wrap (count=limit=5, ctrl=1) -> count=0, loop=0, enable=0 (clear wins); out_valid=0 two cycles later.
- rst_n pulsed low mid-bounce (dir=down, count=2) -> all outputs 0 immediately; after release, counting restarts 1,2,… in the up direction; repeat with DELAY=0 and limit=0 -> loop every cycle, out=count with no delay.
